// File: rtl/uart_pkg.sv
// Shared types for the UART TX arbiter and the round-robin picker.
// No logic here: state encoding and width helper only.
// Imported by every file of the block.
package uart_pkg;

  // Arbiter states: ARB holds no grant, XFER holds one.
  typedef enum logic {
    ARB  = 1'b0,
    XFER = 1'b1
  } arb_state_t;

  // Width of an index into n items, never less than one bit.
  function automatic int idx_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Purpose: round-robin finder, first set req bit strictly after 'last', wrapping.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller decides when a pick is consumed.
module axis_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_SRC = 4
) (
  input  logic [NUM_SRC-1:0]             req,
  input  logic [idx_width(NUM_SRC)-1:0]  last,
  output logic [idx_width(NUM_SRC)-1:0]  pick,
  output logic                           any
);

  localparam int IDX_W = idx_width(NUM_SRC);

  logic             hi_any;
  logic             lo_any;
  logic [IDX_W-1:0] hi_pick;
  logic [IDX_W-1:0] lo_pick;

  // Two scans: lowest requester above 'last', and lowest requester overall.
  // The overall scan is the wrap-around answer (it may be 'last' itself).
  always_comb begin
    hi_any  = 1'b0;
    lo_any  = 1'b0;
    hi_pick = '0;
    lo_pick = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!hi_any && req[i] && (IDX_W'(i) > last)) begin
        hi_any  = 1'b1;
        hi_pick = IDX_W'(i);
      end
      if (!lo_any && req[i]) begin
        lo_any  = 1'b1;
        lo_pick = IDX_W'(i);
      end
    end
  end

  // Prefer the requester above 'last'; otherwise wrap to the lowest one.
  always_comb begin
    any  = hi_any | lo_any;
    pick = hi_any ? hi_pick : lo_pick;
  end

endmodule

// File: rtl/axis_uart_tx_arbiter.sv
// Purpose: round-robin packet arbiter sharing one AXI-Stream UART TX path between NUM_SRC sources.
// Latency: one ARB cycle to grant, then zero-latency combinational pass-through of the granted source.
// Backpressure: m_tready is routed only to the granted source; a stalled idle source is revoked by the watchdog.
module axis_uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int NUM_SRC        = 4,
  parameter int TIMEOUT        = 4096
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic [NUM_SRC*AXI_DATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_SRC-1:0]                  s_tvalid,
  input  logic [NUM_SRC-1:0]                  s_tlast,
  output logic [NUM_SRC-1:0]                  s_tready,
  output logic [AXI_DATA_WIDTH-1:0]           m_tdata,
  output logic                                m_tvalid,
  output logic                                m_tlast,
  output logic [idx_width(NUM_SRC)-1:0]       m_tid,
  input  logic                                m_tready,
  input  logic [NUM_SRC-1:0]                  src_en,
  output logic                                busy,
  output logic                                timeout_err
);

  localparam int IDX_W = idx_width(NUM_SRC);
  localparam int WDT_W = idx_width(TIMEOUT);
  // Counter value at which an idle granted source loses its grant.
  localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_q,  last_d;
  logic [WDT_W-1:0]   wdt_cnt_q, wdt_cnt_d;
  logic               timeout_err_q, timeout_err_d;

  logic [NUM_SRC-1:0]        req;
  logic [IDX_W-1:0]          pick;
  logic                      any;
  logic                      sel_vld;
  logic                      sel_last;
  logic [AXI_DATA_WIDTH-1:0] sel_dat;

  // Only enabled sources with a word waiting compete for the link.
  always_comb begin
    req = s_tvalid & src_en;
  end

  axis_rr_pick #(
    .NUM_SRC (NUM_SRC)
  ) u_pick (
    .req  (req),
    .last (last_q),
    .pick (pick),
    .any  (any)
  );

  // Mux the granted source's beat; constant-index loop keeps the select narrow.
  always_comb begin
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_dat  = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel_vld  = s_tvalid[i];
        sel_last = s_tlast[i];
        sel_dat  = s_tdata[i*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
      end
    end
  end

  // State register plus grant, round-robin pointer, watchdog and error pulse.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q       <= ARB;
      grant_q       <= '0;
      last_q        <= IDX_W'(NUM_SRC - 1);
      wdt_cnt_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_q        <= last_d;
      wdt_cnt_q     <= wdt_cnt_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Next state: grant in ARB; in XFER release on tlast handshake or on watchdog expiry.
  // A handshake implies a valid source, so end-of-packet and timeout never collide.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    wdt_cnt_d     = wdt_cnt_q;
    timeout_err_d = 1'b0;
    unique case (state_q)
      ARB: begin
        if (any) begin
          grant_d   = pick;
          state_d   = XFER;
          wdt_cnt_d = '0;
        end
      end
      XFER: begin
        if (sel_vld) begin
          // Any valid cycle, including a downstream stall, keeps the grant alive.
          wdt_cnt_d = '0;
          if (m_tready && sel_last) begin
            last_d  = grant_q;
            state_d = ARB;
          end
        end else if (TIMEOUT != 0) begin
          if (wdt_cnt_q == WDT_MAX) begin
            // Revoke without tlast: downstream sees a truncated packet.
            last_d        = grant_q;
            state_d       = ARB;
            timeout_err_d = 1'b1;
            wdt_cnt_d     = '0;
          end else begin
            wdt_cnt_d = wdt_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  // Outputs: pass-through of the granted source in XFER, quiet bus otherwise.
  always_comb begin
    busy        = (state_q == XFER);
    timeout_err = timeout_err_q;
    m_tid       = grant_q;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    m_tdata     = '0;
    s_tready    = '0;
    if (state_q == XFER) begin
      m_tvalid = sel_vld;
      m_tlast  = sel_last;
      m_tdata  = sel_dat;
      for (int i = 0; i < NUM_SRC; i++) begin
        s_tready[i] = (grant_q == IDX_W'(i)) && m_tready;
      end
    end
  end

endmodule

// File: tb/tb_axis_uart_tx_arbiter.sv
// Bench for axis_uart_tx_arbiter: per-source packet drivers, a scoreboard of expected beats,
// and a monitor that pops and compares on every downstream handshake.
// Directed scenarios: single packet, rotation, no interleave, stall, watchdog, enable mask, reset.
module tb_axis_uart_tx_arbiter;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int T  = 4096;
  localparam int IW = 2;

  logic              aclk;
  logic              areset;
  logic [N*W-1:0]    s_tdata;
  logic [N-1:0]      s_tvalid;
  logic [N-1:0]      s_tlast;
  logic [N-1:0]      s_tready;
  logic [W-1:0]      m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic [IW-1:0]     m_tid;
  logic              m_tready;
  logic [N-1:0]      src_en;
  logic              busy;
  logic              timeout_err;

  axis_uart_tx_arbiter #(
    .AXI_DATA_WIDTH (W),
    .NUM_SRC        (N),
    .TIMEOUT        (T)
  ) dut (
    .aclk        (aclk),
    .areset      (areset),
    .s_tdata     (s_tdata),
    .s_tvalid    (s_tvalid),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tlast     (m_tlast),
    .m_tid       (m_tid),
    .m_tready    (m_tready),
    .src_en      (src_en),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  logic [32:0] src_q [N][$];   // {tlast, tdata} per source
  logic [34:0] exp_q [$];      // {tid, tlast, tdata} in expected link order
  int          hs_log [$];     // cycle of each downstream handshake
  int          n_chk = 0;
  int          n_pass = 0;
  int          terr_cnt = 0;
  int          terr_cyc = 0;
  logic        terr_busy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic send(input int s, input logic [31:0] d, input logic l);
    src_q[s].push_back({l, d});
  endtask

  task automatic expect_beat(input int s, input logic [31:0] d, input logic l);
    exp_q.push_back({IW'(s), l, d});
  endtask

  task automatic wait_drain(input int budget, input string name);
    int k = 0;
    while (exp_q.size() > 0 && k < budget) begin
      @(negedge aclk);
      k++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic flush_all();
    for (int i = 0; i < N; i++) src_q[i].delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    @(posedge aclk);
    #1 areset = 1'b1;
    flush_all();
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    hs_log.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " busy"},        64'(busy),        64'd0);
    check({tag, " timeout_err"}, 64'(timeout_err), 64'd0);
    check({tag, " s_tready"},    64'(s_tready),    64'd0);
    check({tag, " m_tvalid"},    64'(m_tvalid),    64'd0);
    check({tag, " m_tlast"},     64'(m_tlast),     64'd0);
    check({tag, " m_tdata"},     64'(m_tdata),     64'd0);
    check({tag, " m_tid"},       64'(m_tid),       64'd0);
  endtask

  // Source drivers: present the head of each queue, pop it once it has handshaken.
  initial begin
    bit          hs [N];
    logic [32:0] junk;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tdata  = '0;
    forever begin
      @(negedge aclk);
      for (int i = 0; i < N; i++) hs[i] = s_tvalid[i] && s_tready[i];
      @(posedge aclk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs[i] && src_q[i].size() > 0) junk = src_q[i].pop_front();
        if (src_q[i].size() > 0) begin
          s_tvalid[i]        = 1'b1;
          s_tdata[i*W +: W]  = src_q[i][0][31:0];
          s_tlast[i]         = src_q[i][0][32];
        end else begin
          s_tvalid[i] = 1'b0;
          s_tlast[i]  = 1'b0;
        end
      end
    end
  end

  // Monitor: every downstream handshake pops the scoreboard; watchdog pulses are logged.
  initial begin
    logic [34:0] e;
    forever begin
      @(negedge aclk);
      if (!areset && m_tvalid && m_tready) begin
        hs_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("unexpected beat", 64'({m_tid, m_tlast, m_tdata}), 64'h7_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("beat", 64'({m_tid, m_tlast, m_tdata}), 64'(e));
        end
      end
      if (!areset && timeout_err) begin
        terr_cnt++;
        terr_cyc  = cyc;
        terr_busy = busy;
      end
    end
  end

  initial begin
    int t0;
    int k;
    int bad;
    int d_cyc;

    areset   = 1'b1;
    m_tready = 1'b0;
    src_en   = '1;
    repeat (3) @(posedge aclk);
    #1 areset = 1'b0;
    @(negedge aclk);
    check_reset_outputs("reset");

    // 1: single 3-beat packet from src0, one word per cycle right after the grant.
    m_tready = 1'b1;
    hs_log.delete();
    t0 = cyc + 1;
    send(0, 32'hA1, 1'b0); send(0, 32'hA2, 1'b0); send(0, 32'hA3, 1'b1);
    expect_beat(0, 32'hA1, 1'b0); expect_beat(0, 32'hA2, 1'b0); expect_beat(0, 32'hA3, 1'b1);
    while (cyc < t0 + 3) @(negedge aclk);
    check("t1 busy on tlast beat", 64'(busy), 64'd1);
    @(negedge aclk);
    check("t1 busy after tlast", 64'(busy), 64'd0);
    wait_drain(10, "t1 drain");
    check("t1 beat count", 64'(hs_log.size()), 64'd3);
    for (int i = 0; i < 3 && i < hs_log.size(); i++)
      check("t1 beat cycle", 64'(hs_log[i]), 64'(t0 + 1 + i));

    // 2: everyone requests single-beat packets, rotation 0,1,2,3,0 with one ARB gap.
    do_reset();
    @(negedge aclk);
    t0 = cyc + 1;
    send(0, 32'hB0, 1'b1); send(0, 32'hB4, 1'b1);
    send(1, 32'hB1, 1'b1); send(2, 32'hB2, 1'b1); send(3, 32'hB3, 1'b1);
    expect_beat(0, 32'hB0, 1'b1); expect_beat(1, 32'hB1, 1'b1); expect_beat(2, 32'hB2, 1'b1);
    expect_beat(3, 32'hB3, 1'b1); expect_beat(0, 32'hB4, 1'b1);
    wait_drain(40, "t2 drain");
    check("t2 beat count", 64'(hs_log.size()), 64'd5);
    if (hs_log.size() > 0) check("t2 first beat", 64'(hs_log[0]), 64'(t0 + 1));
    for (int i = 1; i < hs_log.size(); i++)
      check("t2 packet spacing", 64'(hs_log[i] - hs_log[i-1]), 64'd2);

    // 3: src2 waits for the whole src1 packet; no interleaving.
    do_reset();
    @(negedge aclk);
    send(1, 32'h31, 1'b0); send(1, 32'h32, 1'b0); send(1, 32'h33, 1'b1);
    send(2, 32'h41, 1'b0); send(2, 32'h42, 1'b1);
    expect_beat(1, 32'h31, 1'b0); expect_beat(1, 32'h32, 1'b0); expect_beat(1, 32'h33, 1'b1);
    expect_beat(2, 32'h41, 1'b0); expect_beat(2, 32'h42, 1'b1);
    k = 0;
    while (exp_q.size() > 0 && k < 40) begin
      @(negedge aclk);
      k++;
      if (busy && m_tid == 2'd1) check("t3 src2 blocked", 64'(s_tready[2]), 64'd0);
    end
    check("t3 drain", 64'(exp_q.size()), 64'd0);

    // 4: long downstream stall with valid held never trips the watchdog.
    m_tready = 1'b0;
    do_reset();
    terr_cnt = 0;
    @(negedge aclk);
    t0 = cyc + 1;
    send(0, 32'hC0DE0000, 1'b1);
    expect_beat(0, 32'hC0DE0000, 1'b1);
    while (cyc < t0 + 1) @(negedge aclk);
    bad = 0;
    repeat (10000) begin
      @(negedge aclk);
      if (m_tdata !== 32'hC0DE0000 || m_tvalid !== 1'b1 || busy !== 1'b1 || m_tid !== 2'd0) bad++;
    end
    check("t4 held stable", 64'(bad), 64'd0);
    check("t4 no timeout", 64'(terr_cnt), 64'd0);
    @(posedge aclk);
    #1 m_tready = 1'b1;
    wait_drain(10, "t4 drain");
    @(negedge aclk);
    check("t4 busy released", 64'(busy), 64'd0);

    // 5: src3 goes idle mid-packet; watchdog revokes after TIMEOUT idle cycles, src0 next.
    do_reset();
    terr_cnt = 0;
    @(negedge aclk);
    send(3, 32'hD0, 1'b0);
    expect_beat(3, 32'hD0, 1'b0);
    wait_drain(20, "t5 first beat");
    d_cyc = (hs_log.size() > 0) ? hs_log[hs_log.size()-1] : 0;
    send(0, 32'hE0, 1'b1); send(1, 32'hF0, 1'b1);
    expect_beat(0, 32'hE0, 1'b1); expect_beat(1, 32'hF0, 1'b1);
    hs_log.delete();
    k = 0;
    while (terr_cnt == 0 && k < T + 50) begin
      @(negedge aclk);
      k++;
    end
    check("t5 timeout fired", 64'(terr_cnt), 64'd1);
    check("t5 timeout delay", 64'(terr_cyc - d_cyc), 64'(T + 1));
    check("t5 busy at pulse", 64'(terr_busy), 64'd0);
    wait_drain(20, "t5 drain");
    check("t5 pulse width", 64'(terr_cnt), 64'd1);
    if (hs_log.size() > 0) check("t5 src0 regrant", 64'(hs_log[0]), 64'(terr_cyc + 1));

    // 6: enable mask 1010 alternates 1,3; then reset mid-packet clears everything.
    do_reset();
    src_en = 4'b1010;
    @(negedge aclk);
    send(0, 32'h60, 1'b1); send(0, 32'h65, 1'b1);
    send(1, 32'h61, 1'b1); send(1, 32'h62, 1'b1);
    send(2, 32'h66, 1'b1); send(2, 32'h67, 1'b1);
    send(3, 32'h63, 1'b1); send(3, 32'h64, 1'b1);
    expect_beat(1, 32'h61, 1'b1); expect_beat(3, 32'h63, 1'b1);
    expect_beat(1, 32'h62, 1'b1); expect_beat(3, 32'h64, 1'b1);
    wait_drain(40, "t6 mask drain");
    src_q[0].delete();
    src_q[2].delete();
    repeat (3) @(negedge aclk);
    check("t6 masked idle", 64'(busy), 64'd0);
    src_en = '1;
    send(1, 32'h71, 1'b0); send(1, 32'h72, 1'b0); send(1, 32'h73, 1'b1);
    expect_beat(1, 32'h71, 1'b0);
    wait_drain(20, "t6 first beat");
    @(posedge aclk);
    #1;
    areset   = 1'b1;
    m_tready = 1'b0;
    @(negedge aclk);
    check("t6 mid-packet", 64'(busy), 64'd1);
    @(negedge aclk);
    check_reset_outputs("t6 areset");
    flush_all();
    repeat (2) @(posedge aclk);
    #1 areset = 1'b0;
    m_tready = 1'b1;
    repeat (4) @(negedge aclk);
    check("t6 idle after reset", 64'(busy), 64'd0);

    check("final scoreboard empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
